// File: rtl/soc_box_counter_pkg.sv
// Shared types and constants for the per-frame box counter.
// Holds the FSM encoding, default geometry limits and the saturating increment helper.
package soc_box_counter_pkg;

    localparam int CNT_W       = 8;
    localparam int FCNT_W      = 16;

    localparam int DEF_COORD_W = 11;
    localparam int DEF_MIN_W   = 8;
    localparam int DEF_MIN_H   = 8;
    localparam int DEF_MAX_W   = 640;
    localparam int DEF_MAX_H   = 480;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_DRAIN0 = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_LATCH  = 3'd4
    } state_e;

    // Returns {attempted_overflow, next_count}; the count sticks at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = {1'b1, cnt};
        end else begin
            res = {1'b0, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_box_size_filter.sv
// Two-stage box size filter: stage 1 derives width/height and malformed flag,
// stage 2 applies the inclusive min/max window and raises hit_valid_o.
module soc_box_size_filter
    import soc_box_counter_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int MIN_W   = DEF_MIN_W,
    parameter int MIN_H   = DEF_MIN_H,
    parameter int MAX_W   = DEF_MAX_W,
    parameter int MAX_H   = DEF_MAX_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               in_valid_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] y1_i,
    output logic               hit_valid_o
);

    localparam int DIM_W = COORD_W + 1;
    localparam logic [DIM_W-1:0] MIN_W_C = DIM_W'(MIN_W);
    localparam logic [DIM_W-1:0] MIN_H_C = DIM_W'(MIN_H);
    localparam logic [DIM_W-1:0] MAX_W_C = DIM_W'(MAX_W);
    localparam logic [DIM_W-1:0] MAX_H_C = DIM_W'(MAX_H);
    localparam logic [DIM_W-1:0] ONE_C   = DIM_W'(1);

    logic [DIM_W-1:0] w_d;
    logic [DIM_W-1:0] w_q;
    logic [DIM_W-1:0] h_d;
    logic [DIM_W-1:0] h_q;
    logic             bad_d;
    logic             bad_q;
    logic             s1_valid_d;
    logic             s1_valid_q;
    logic             hit_d;
    logic             hit_q;

    // Stage 1: inclusive extents; the wrapped value of a malformed box is masked by bad_d.
    always_comb begin
        w_d        = ({1'b0, x1_i} - {1'b0, x0_i}) + ONE_C;
        h_d        = ({1'b0, y1_i} - {1'b0, y0_i}) + ONE_C;
        bad_d      = (x1_i < x0_i) || (y1_i < y0_i);
        s1_valid_d = in_valid_i;
    end

    // Stage 2: range window; a flush drops whatever stage 1 holds.
    always_comb begin
        hit_d = 1'b0;
        if (s1_valid_q && !flush_i && !bad_q) begin
            hit_d = (w_q >= MIN_W_C) && (w_q <= MAX_W_C) &&
                    (h_q >= MIN_H_C) && (h_q <= MAX_H_C);
        end else begin
            hit_d = 1'b0;
        end
    end

    // Pipeline registers with a valid bit per stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q        <= {DIM_W{1'b0}};
            h_q        <= {DIM_W{1'b0}};
            bad_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            w_q        <= w_d;
            h_q        <= h_d;
            bad_q      <= bad_d;
            s1_valid_q <= s1_valid_d;
            hit_q      <= hit_d;
        end
    end

    assign hit_valid_o = hit_q;

endmodule

// File: rtl/soc_box_counter.sv
// Per-frame accepted-box counter feeding the box-count PIO.
// Frame FSM, saturating running count and the registered frame-level outputs.
module soc_box_counter
    import soc_box_counter_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int MIN_W   = DEF_MIN_W,
    parameter int MIN_H   = DEF_MIN_H,
    parameter int MAX_W   = DEF_MAX_W,
    parameter int MAX_H   = DEF_MAX_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               box_valid,
    output logic               box_ready,
    input  logic [COORD_W-1:0] box_x0,
    input  logic [COORD_W-1:0] box_x1,
    input  logic [COORD_W-1:0] box_y0,
    input  logic [COORD_W-1:0] box_y1,
    output logic [CNT_W-1:0]   box_n,
    output logic               box_n_update,
    output logic               box_ovf,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               sync_err
);

    state_e              state_d;
    state_e              state_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                fovf_d;
    logic                fovf_q;
    logic [CNT_W-1:0]    box_n_d;
    logic [CNT_W-1:0]    box_n_q;
    logic                upd_d;
    logic                upd_q;
    logic                ovf_d;
    logic                ovf_q;
    logic [FCNT_W-1:0]   fcnt_d;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                err_d;
    logic                err_q;
    logic                ready_d;
    logic                ready_q;

    logic                accept_s;
    logic                clear_s;
    logic                latch_s;
    logic                hit_s;
    logic [CNT_W:0]      inc_s;

    assign accept_s = box_valid && ready_q;

    // Only boxes handshaken while a frame is open enter the filter; a restart flushes it.
    soc_box_size_filter #(
        .COORD_W (COORD_W),
        .MIN_W   (MIN_W),
        .MIN_H   (MIN_H),
        .MAX_W   (MAX_W),
        .MAX_H   (MAX_H)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (clear_s),
        .in_valid_i  (accept_s && (state_q == ST_ACTIVE)),
        .x0_i        (box_x0),
        .x1_i        (box_x1),
        .y0_i        (box_y0),
        .y1_i        (box_y1),
        .hit_valid_o (hit_s)
    );

    // Frame FSM next state, count clear, latch strobe and marker ordering errors.
    always_comb begin
        state_d = state_q;
        clear_s = 1'b0;
        latch_s = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ACTIVE;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
                if (frame_end) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_ACTIVE: begin
                // End wins over a coincident start; the start is still an ordering error.
                if (frame_end) begin
                    state_d = ST_DRAIN0;
                    err_d   = err_q | frame_start;
                end else if (frame_start) begin
                    clear_s = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DRAIN0: begin
                state_d = ST_DRAIN1;
                err_d   = err_q | frame_start | frame_end;
            end
            ST_DRAIN1: begin
                state_d = ST_LATCH;
                err_d   = err_q | frame_start | frame_end;
            end
            ST_LATCH: begin
                latch_s = 1'b1;
                err_d   = err_q | frame_end;
                if (frame_start) begin
                    state_d = ST_ACTIVE;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Running count with saturation; the overflow bit remembers any increment lost at 255.
    always_comb begin
        inc_s  = sat_inc(cnt_q);
        cnt_d  = cnt_q;
        fovf_d = fovf_q;
        if (clear_s) begin
            cnt_d  = {CNT_W{1'b0}};
            fovf_d = 1'b0;
        end else if (hit_s) begin
            cnt_d  = inc_s[CNT_W-1:0];
            fovf_d = fovf_q | inc_s[CNT_W];
        end else begin
            cnt_d  = cnt_q;
            fovf_d = fovf_q;
        end
    end

    // Frame-level output next values, including ready derived from the upcoming state.
    always_comb begin
        box_n_d = box_n_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;
        fcnt_d  = fcnt_q;
        ready_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
        if (latch_s) begin
            box_n_d = cnt_q;
            ovf_d   = fovf_q;
            upd_d   = 1'b1;
            fcnt_d  = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
        end else begin
            upd_d   = 1'b0;
        end
    end

    // State, count and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            fovf_q  <= 1'b0;
            box_n_q <= {CNT_W{1'b0}};
            upd_q   <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= {FCNT_W{1'b0}};
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fovf_q  <= fovf_d;
            box_n_q <= box_n_d;
            upd_q   <= upd_d;
            ovf_q   <= ovf_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign box_ready    = ready_q;
    assign box_n        = box_n_q;
    assign box_n_update = upd_q;
    assign box_ovf      = ovf_q;
    assign frame_cnt    = fcnt_q;
    assign sync_err     = err_q;

endmodule

// File: tb/tb_soc_box_counter.sv
// Bench for soc_box_counter: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_soc_box_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        frame_end;
    logic        box_valid;
    logic        box_ready;
    logic [10:0] box_x0;
    logic [10:0] box_x1;
    logic [10:0] box_y0;
    logic [10:0] box_y1;
    logic [7:0]  box_n;
    logic        box_n_update;
    logic        box_ovf;
    logic [15:0] frame_cnt;
    logic        sync_err;

    int total = 0;
    int bad   = 0;

    soc_box_counter dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .box_valid    (box_valid),
        .box_ready    (box_ready),
        .box_x0       (box_x0),
        .box_x1       (box_x1),
        .box_y0       (box_y0),
        .box_y1       (box_y1),
        .box_n        (box_n),
        .box_n_update (box_n_update),
        .box_ovf      (box_ovf),
        .frame_cnt    (frame_cnt),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: frame open flag, cycles left before ready returns, unsaturated total.
    bit e_ready, e_upd, e_ovf, e_err, m_active, chk_en;
    int e_n, e_fc, m_busy, m_total;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit box_ok(input int x0, input int x1, input int y0, input int y1);
        int w, h;
        if (x1 < x0 || y1 < y0) return 1'b0;
        w = x1 - x0 + 1;
        h = y1 - y0 + 1;
        return (w >= 8 && w <= 640 && h >= 8 && h <= 480);
    endfunction

    task automatic model_reset();
        e_ready = 1'b1; e_upd = 1'b0; e_ovf = 1'b0; e_err = 1'b0;
        e_n = 0; e_fc = 0; m_busy = 0; m_total = 0; m_active = 1'b0;
    endtask

    task automatic model_step();
        bit hs;
        hs = box_valid && e_ready;
        e_upd = 1'b0;
        if (m_busy > 0) begin
            if (frame_end) e_err = 1'b1;
            if (m_busy == 1) begin
                e_n   = (m_total > 255) ? 255 : m_total;
                e_ovf = (m_total > 255);
                e_upd = 1'b1;
                e_fc  = (e_fc + 1) % 65536;
                m_active = frame_start;
                if (frame_start) m_total = 0;
            end else if (frame_start) begin
                e_err = 1'b1;
            end
            m_busy--;
        end else if (m_active) begin
            if (frame_start) e_err = 1'b1;
            if (frame_start && !frame_end) m_total = 0;
            if (hs && box_ok(box_x0, box_x1, box_y0, box_y1)) m_total++;
            if (frame_end) m_busy = 3;
        end else begin
            if (frame_end) e_err = 1'b1;
            if (frame_start) begin
                m_active = 1'b1;
                m_total  = 0;
            end
        end
        e_ready = (m_busy == 0);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready",  box_ready,    e_ready);
            check("cyc_box_n",  box_n,        e_n);
            check("cyc_update", box_n_update, e_upd);
            check("cyc_ovf",    box_ovf,      e_ovf);
            check("cyc_fcnt",   frame_cnt,    e_fc);
            check("cyc_err",    sync_err,     e_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
    endtask

    task automatic set_box(input int x0, input int x1, input int y0, input int y1);
        box_x0 = 11'(x0); box_x1 = 11'(x1); box_y0 = 11'(y0); box_y1 = 11'(y1);
    endtask

    task automatic offer(input int x0, input int x1, input int y0, input int y1);
        bit hs;
        int g;
        g = 0;
        box_valid = 1'b1;
        set_box(x0, x1, y0, y1);
        do begin
            hs = box_ready;
            tick();
            g++;
        end while (!hs && g < 20);
        if (!hs) check("handshake_timeout", hs, 1);
        box_valid = 1'b0;
    endtask

    task automatic box_wh(input int w, input int h);
        offer(10, 10 + w - 1, 20, 20 + h - 1);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    // End a frame and pin the drain timing; optionally a box rides the end cycle or waits during drain.
    task automatic end_frame(input int exp_n, input int exp_ovf, input int exp_fc,
                             input bit box_with_end, input bit hold_box);
        frame_end = 1'b1;
        if (box_with_end) begin
            box_valid = 1'b1;
            set_box(100, 119, 100, 119);
        end
        tick();
        frame_end = 1'b0;
        box_valid = hold_box;
        if (hold_box) set_box(200, 219, 200, 219);
        check("ready_e1", box_ready, 0); tick();
        check("ready_e2", box_ready, 0); tick();
        check("ready_e3", box_ready, 0); tick();
        check("ready_e4", box_ready, 1);
        check("upd_e4",   box_n_update, 1);
        check("box_n_e4", box_n, exp_n);
        check("ovf_e4",   box_ovf, exp_ovf);
        check("fcnt_e4",  frame_cnt, exp_fc);
        tick();
        box_valid = 1'b0;
        check("upd_e5", box_n_update, 0);
    endtask

    task automatic rand_dim(output int d);
        case ($urandom_range(0, 4))
            0:       d = $urandom_range(5, 10);
            1:       d = $urandom_range(636, 644);
            2:       d = $urandom_range(476, 484);
            3:       d = $urandom_range(0, 3) - 3;
            default: d = $urandom_range(11, 300);
        endcase
    endtask

    task automatic rand_box();
        int x0, y0, w, h;
        x0 = $urandom_range(4, 1200);
        y0 = $urandom_range(4, 1200);
        rand_dim(w);
        rand_dim(h);
        set_box(x0, x0 + w - 1, y0, y0 + h - 1);
        box_valid = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; box_valid = 1'b0;
        set_box(0, 0, 0, 0);
        model_reset();
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_box_n", box_n, 0);
        check("rst_update", box_n_update, 0);
        check("rst_ovf", box_ovf, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_err", sync_err, 0);
        check("rst_ready", box_ready, 1);

        // Basic frame: five 20x20 boxes.
        pulse_fs();
        repeat (5) box_wh(20, 20);
        end_frame(5, 0, 1, 1'b0, 1'b0);

        // Filter bounds: 8x8 and 640x480 pass; 7x8, 641x10 and malformed fail.
        pulse_fs();
        box_wh(8, 8);
        box_wh(7, 8);
        box_wh(640, 480);
        box_wh(641, 10);
        offer(100, 50, 0, 20);
        end_frame(2, 0, 2, 1'b0, 1'b0);

        // Saturation, then a clean frame clears the overflow.
        pulse_fs();
        repeat (300) box_wh(20, 20);
        end_frame(255, 1, 3, 1'b0, 1'b0);
        pulse_fs();
        repeat (3) box_wh(20, 20);
        end_frame(3, 0, 4, 1'b0, 1'b0);
        check("no_err_yet", sync_err, 0);

        // Box coincident with end is counted; a box held during drain lands in IDLE.
        pulse_fs();
        repeat (2) box_wh(20, 20);
        end_frame(3, 0, 5, 1'b1, 1'b1);
        pulse_fs();
        end_frame(0, 0, 6, 1'b0, 1'b0);

        // End marker in IDLE.
        pulse_fs();
        box_wh(30, 30);
        end_frame(1, 0, 7, 1'b0, 1'b0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("idle_end_err", sync_err, 1);
        check("idle_end_box_n", box_n, 1);

        // Restart mid-frame discards the partial count, including boxes still in the filter.
        pulse_fs();
        repeat (4) box_wh(20, 20);
        pulse_fs();
        repeat (2) box_wh(20, 20);
        end_frame(2, 0, 8, 1'b0, 1'b0);

        // Reset while in DRAIN1.
        pulse_fs();
        box_wh(20, 20);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_box_n", box_n, 0);
        check("mid_rst_update", box_n_update, 0);
        check("mid_rst_ovf", box_ovf, 0);
        check("mid_rst_fcnt", frame_cnt, 0);
        check("mid_rst_err", sync_err, 0);
        check("mid_rst_ready", box_ready, 1);
        tick();
        reset = 1'b0;
        pulse_fs();
        box_wh(20, 20);
        end_frame(1, 0, 1, 1'b0, 1'b0);

        // Randomized frames with varying gaps, stray markers and boundary-heavy boxes.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                frame_end = 1'b1; tick(); frame_end = 1'b0;
            end
            frame_start = 1'b1; rand_box(); tick(); frame_start = 1'b0;
            for (int c = 0; c < int'($urandom_range(0, 30)); c++) begin
                rand_box();
                frame_start = ($urandom_range(0, 39) == 0);
                tick();
                frame_start = 1'b0;
            end
            frame_end = 1'b1; rand_box(); tick(); frame_end = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) begin
                rand_box();
                tick();
            end
            box_valid = 1'b0;
        end
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
